// File: rtl/front2_arb_pkg.sv
// Shared types and constants for the Front2 sprite-SRAM arbiter:
// FSM states, strobe reset levels and the phase-counter width helper.
package front2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_WIN = 2'd1,
    ACCESS   = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  localparam logic V_C_RST    = 1'b0;
  localparam logic VCKN_RST   = 1'b1;
  localparam logic H3_RST     = 1'b0;
  localparam logic VRD_RST    = 1'b0;
  localparam logic VDG_RST    = 1'b1;
  localparam logic VOE_RST    = 1'b1;
  localparam logic VWE_RST    = 1'b1;
  localparam logic WAIT_N_RST = 1'b1;

  // Bits needed to count 0..slot_len-1 (slot_len is a power of two, >= 4).
  function automatic int phase_width(input int slot_len);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < slot_len) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/front2_slot_timer.sv
// Slot phase counter stepped by pix_cen, realigned by line_start, plus
// look-ahead qualifiers describing the phase that becomes current next clk.
module front2_slot_timer
  import front2_arb_pkg::*;
#(
  parameter int SLOT_LEN      = 8,
  parameter int CPU_WIN_START = 4,
  localparam int PW           = phase_width(SLOT_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_cen,
  input  logic          line_start,
  input  logic          vblank,
  output logic [PW-1:0] phase,
  output logic          h3_nxt,
  output logic          cpu_win_next,
  output logic          video_win
);

  localparam logic [PW-1:0] WIN_START = PW'(CPU_WIN_START);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // SLOT_LEN is a power of two, so the natural wrap of phase_q is the modulo.
  always_comb begin
    phase_d = phase_q;
    if (line_start) begin
      phase_d = '0;
    end else if (pix_cen) begin
      phase_d = phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase        = phase_q;
  assign h3_nxt       = phase_d[1];
  assign cpu_win_next = pix_cen && (phase_d == WIN_START);
  assign video_win    = (phase_d < WIN_START) && !vblank;

endmodule

// File: rtl/front2_sram_arbiter.sv
// Front2 sprite-SRAM time-share between CPU video bus and sprite fetch.
// Optional FRONT2_ARB_STATS_EN adds a saturating wait-cycle counter.
module front2_sram_arbiter
  import front2_arb_pkg::*;
#(
  parameter int SLOT_LEN      = 8,
  parameter int CPU_WIN_START = 4,
  parameter int ACC_TICKS     = 2,
  localparam int PW           = phase_width(SLOT_LEN)
) (
  input  logic          clk,
  input  logic          VIDEO_RSTn,
  input  logic          pix_cen,
  input  logic          line_start,
  input  logic          vblank,
  input  logic          cpu_cs_n,
  input  logic          cpu_rd_n,
  input  logic          cpu_wr_n,
  output logic          cpu_wait_n,
  output logic          V_C,
  output logic          VCKn,
  output logic          H3,
  output logic [PW-1:0] phase,
  output logic          VRD,
  output logic          VDG,
  output logic          VOE,
  output logic          VWE
`ifdef FRONT2_ARB_STATS_EN
  ,
  output logic [15:0]   wait_cycles
`endif
);

  localparam logic [PW-1:0] LAST_TICK = PW'(ACC_TICKS - 1);

  arb_state_t    state_q, state_d;
  logic          we_q, we_d;
  logic [PW-1:0] tick_q, tick_d;

  logic v_c_q, vckn_q, h3_q, vrd_q, vdg_q, voe_q, vwe_q, wait_n_q;
  logic v_c_d, vckn_d, h3_d, vrd_d, vdg_d, voe_d, vwe_d, wait_n_d;

  logic h3_nxt, cpu_win_next, video_win;
  logic cpu_req, acc_d, fin_d;

  front2_slot_timer #(
    .SLOT_LEN      (SLOT_LEN),
    .CPU_WIN_START (CPU_WIN_START)
  ) u_slot_timer (
    .clk          (clk),
    .rst_n        (VIDEO_RSTn),
    .pix_cen      (pix_cen),
    .line_start   (line_start),
    .vblank       (vblank),
    .phase        (phase),
    .h3_nxt       (h3_nxt),
    .cpu_win_next (cpu_win_next),
    .video_win    (video_win)
  );

  assign cpu_req = !cpu_cs_n && (!cpu_rd_n || !cpu_wr_n);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    tick_d  = tick_q;
    case (state_q)
      IDLE: begin
        // Write wins when both strobes are low.
        if (cpu_req) begin
          state_d = WAIT_WIN;
          we_d    = !cpu_wr_n;
        end
      end
      WAIT_WIN: begin
        if (cpu_cs_n) begin
          state_d = IDLE;
        end else if (pix_cen && (vblank || cpu_win_next)) begin
          state_d = ACCESS;
          tick_d  = '0;
        end
      end
      ACCESS: begin
        if (pix_cen) begin
          if (tick_q == LAST_TICK) state_d = DONE;
          else                     tick_d  = tick_q + PW'(1);
        end
      end
      DONE: begin
        if (cpu_cs_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so every output is a flop.
    acc_d    = (state_d == ACCESS);
    fin_d    = acc_d && (tick_d == LAST_TICK);
    v_c_d    = acc_d;
    vdg_d    = !acc_d;
    vrd_d    = acc_d && we_d;
    voe_d    = !(acc_d && !we_d);
    vwe_d    = !(fin_d && we_d);
    wait_n_d = !((state_d == WAIT_WIN) || acc_d);
    vckn_d   = !(video_win && !acc_d);
    h3_d     = h3_nxt;
  end

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      tick_q  <= tick_d;
    end
  end

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      v_c_q    <= V_C_RST;
      vckn_q   <= VCKN_RST;
      h3_q     <= H3_RST;
      vrd_q    <= VRD_RST;
      vdg_q    <= VDG_RST;
      voe_q    <= VOE_RST;
      vwe_q    <= VWE_RST;
      wait_n_q <= WAIT_N_RST;
    end else begin
      v_c_q    <= v_c_d;
      vckn_q   <= vckn_d;
      h3_q     <= h3_d;
      vrd_q    <= vrd_d;
      vdg_q    <= vdg_d;
      voe_q    <= voe_d;
      vwe_q    <= vwe_d;
      wait_n_q <= wait_n_d;
    end
  end

  assign V_C        = v_c_q;
  assign VCKn       = vckn_q;
  assign H3         = h3_q;
  assign VRD        = vrd_q;
  assign VDG        = vdg_q;
  assign VOE        = voe_q;
  assign VWE        = vwe_q;
  assign cpu_wait_n = wait_n_q;

`ifdef FRONT2_ARB_STATS_EN
  logic [15:0] wait_cnt_q;

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      wait_cnt_q <= '0;
    end else if (!wait_n_q && (wait_cnt_q != 16'hFFFF)) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  assign wait_cycles = wait_cnt_q;
`endif

endmodule

// File: tb/tb_front2_sram_arbiter.sv
// Bench for front2_sram_arbiter: fixed vector table, corner-case sequences
// and random traffic against a request-level reference model.
module tb_front2_sram_arbiter;

  localparam int SLOT  = 8;
  localparam int START = 4;
  localparam int ACC   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_cen = 1'b0, line_start = 1'b0, vblank = 1'b0;
  logic       cpu_cs_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
  logic       cpu_wait_n, V_C, VCKn, H3, VRD, VDG, VOE, VWE;
  logic [2:0] phase;
`ifdef FRONT2_ARB_STATS_EN
  logic [15:0] wait_cycles;
`endif

  always #5 clk = ~clk;

  front2_sram_arbiter #(
    .SLOT_LEN      (SLOT),
    .CPU_WIN_START (START),
    .ACC_TICKS     (ACC)
  ) dut (
    .clk        (clk),
    .VIDEO_RSTn (rst_n),
    .pix_cen    (pix_cen),
    .line_start (line_start),
    .vblank     (vblank),
    .cpu_cs_n   (cpu_cs_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_wait_n (cpu_wait_n),
    .V_C        (V_C),
    .VCKn       (VCKn),
    .H3         (H3),
    .phase      (phase),
    .VRD        (VRD),
    .VDG        (VDG),
    .VOE        (VOE),
    .VWE        (VWE)
`ifdef FRONT2_ARB_STATS_EN
    ,
    .wait_cycles (wait_cycles)
`endif
  );

  // {phase, V_C, VCKn, H3, VRD, VDG, VOE, VWE, cpu_wait_n}
  logic [10:0] obs;
  assign obs = {phase, V_C, VCKn, H3, VRD, VDG, VOE, VWE, cpu_wait_n};

  int errors = 0;
  int checks = 0;

  function automatic logic [10:0] ev(input int ph, input bit vc, vckn, h3, vrd,
                                     input bit vdg, voe, vwe, wn);
    logic [2:0] p;
    p = 3'(ph);
    return {p, vc, vckn, h3, vrd, vdg, voe, vwe, wn};
  endfunction

  localparam logic [10:0] RESET_VEC = 11'b000_0_1_0_0_1_1_1_1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Reference model: a CPU request is "waiting", then holds the bus for a
  // number of remaining pix_cen ticks, then is "held" until cs_n rises.
  int m_phase, m_left, m_wcnt;
  bit m_wait, m_held, m_we, m_vb;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_wcnt = 0;
    m_wait = 0; m_held = 0; m_we = 0; m_vb = 0;
  endtask

  task automatic model_edge(input bit ls, pc, vb, cs, rd, wr);
    int nph;
    if ((m_wait || m_left > 0) && m_wcnt < 65535) m_wcnt++;
    nph = ls ? 0 : (pc ? (m_phase + 1) % SLOT : m_phase);
    if (m_left > 0) begin
      if (pc) begin
        m_left--;
        if (m_left == 0) m_held = 1;
      end
    end else if (m_held) begin
      if (cs) m_held = 0;
    end else if (m_wait) begin
      if (cs) m_wait = 0;
      else if (pc && (vb || nph == START)) begin
        m_wait = 0;
        m_left = ACC;
      end
    end else if (!cs && (!rd || !wr)) begin
      m_wait = 1;
      m_we   = !wr;
    end
    m_phase = nph;
    m_vb    = vb;
  endtask

  function automatic logic [10:0] model_out();
    bit acc;
    acc = (m_left > 0);
    return ev(m_phase, acc, !(m_phase < START && !m_vb && !acc), ((m_phase >> 1) & 1) != 0,
              acc && m_we, !acc, !(acc && !m_we), !(acc && m_we && m_left == 1),
              !(m_wait || acc));
  endfunction

  task automatic step(input bit ls, pc, vb, cs, rd, wr);
    line_start = ls; pix_cen = pc; vblank = vb;
    cpu_cs_n = cs; cpu_rd_n = rd; cpu_wr_n = wr;
    @(posedge clk);
    #1;
    model_edge(ls, pc, vb, cs, rd, wr);
    check("model", 32'(obs), 32'(model_out()));
`ifdef FRONT2_ARB_STATS_EN
    check("wait_cycles", 32'(wait_cycles), 32'(m_wcnt));
`endif
  endtask

  // Asserts reset mid-cycle, checks the immediate reset values, releases.
  task automatic do_reset(input string name);
    #2 rst_n = 1'b0;
    #1 check(name, 32'(obs), 32'(RESET_VEC));
    line_start = 0; pix_cen = 0; vblank = 0;
    cpu_cs_n = 1; cpu_rd_n = 1; cpu_wr_n = 1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit ls, pc, vb, cs, rd, wr;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[20];
  bit   vdg_all, vwe_all, got;
  bit   r_vb, r_cs, r_rd, r_wr;

  initial begin
    // Read requested at phase 1, write requested at phase 0 of the next slot.
    tbl[0]  = '{0,0,0,1,1,1, ev(0,0,0,0,0,1,1,1,1)};
    tbl[1]  = '{0,1,0,1,1,1, ev(1,0,0,0,0,1,1,1,1)};
    tbl[2]  = '{0,0,0,0,0,1, ev(1,0,0,0,0,1,1,1,0)};
    tbl[3]  = '{0,1,0,0,0,1, ev(2,0,0,1,0,1,1,1,0)};
    tbl[4]  = '{0,1,0,0,0,1, ev(3,0,0,1,0,1,1,1,0)};
    tbl[5]  = '{0,1,0,0,0,1, ev(4,1,1,0,0,0,0,1,0)};
    tbl[6]  = '{0,0,0,0,0,1, ev(4,1,1,0,0,0,0,1,0)};
    tbl[7]  = '{0,1,0,0,0,1, ev(5,1,1,0,0,0,0,1,0)};
    tbl[8]  = '{0,1,0,0,0,1, ev(6,0,1,1,0,1,1,1,1)};
    tbl[9]  = '{0,0,0,1,1,1, ev(6,0,1,1,0,1,1,1,1)};
    tbl[10] = '{0,1,0,1,1,1, ev(7,0,1,1,0,1,1,1,1)};
    tbl[11] = '{0,1,0,1,1,1, ev(0,0,0,0,0,1,1,1,1)};
    tbl[12] = '{0,0,0,0,1,0, ev(0,0,0,0,0,1,1,1,0)};
    tbl[13] = '{0,1,0,0,1,0, ev(1,0,0,0,0,1,1,1,0)};
    tbl[14] = '{0,1,0,0,1,0, ev(2,0,0,1,0,1,1,1,0)};
    tbl[15] = '{0,1,0,0,1,0, ev(3,0,0,1,0,1,1,1,0)};
    tbl[16] = '{0,1,0,0,1,0, ev(4,1,1,0,1,0,1,1,0)};
    tbl[17] = '{0,1,0,0,1,0, ev(5,1,1,0,1,0,1,0,0)};
    tbl[18] = '{0,1,0,0,1,0, ev(6,0,1,1,0,1,1,1,1)};
    tbl[19] = '{0,1,0,1,1,1, ev(7,0,1,1,0,1,1,1,1)};

    @(posedge clk);
    do_reset("reset_initial");

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].ls, tbl[i].pc, tbl[i].vb, tbl[i].cs, tbl[i].rd, tbl[i].wr);
      check($sformatf("table[%0d]", i), 32'(obs), 32'(tbl[i].exp));
    end

    // Idle with pix_cen every 4 clks: phase walks the slot, video fetch runs.
    for (int i = 0; i < 32; i++) step(0, (i % 4) == 3, 0, 1, 1, 1);

    // vblank write: access on the next pix_cen whatever the phase.
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    check("vblank_access_vc", 32'(V_C), 32'(1));
    check("vblank_vckn", 32'(VCKn), 32'(1));
    step(0, 1, 1, 0, 1, 0);
    check("vblank_final_vwe", 32'(VWE), 32'(0));
    step(0, 1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1, 1);

    // Abort in WAIT_WIN: no data gate or write pulse, wait released.
    vdg_all = 1; vwe_all = 1;
    step(0, 0, 0, 0, 1, 0);
    vdg_all &= VDG; vwe_all &= VWE;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 0);
      vdg_all &= VDG; vwe_all &= VWE;
    end
    check("abort_waiting", 32'(cpu_wait_n), 32'(0));
    step(0, 1, 0, 1, 1, 1);
    vdg_all &= VDG; vwe_all &= VWE;
    step(0, 1, 0, 1, 1, 1);
    vdg_all &= VDG; vwe_all &= VWE;
    check("abort_wait_n", 32'(cpu_wait_n), 32'(1));
    check("abort_no_vdg", 32'(vdg_all), 32'(1));
    check("abort_no_vwe", 32'(vwe_all), 32'(1));

    // line_start in the first access tick: access still finishes in 2 ticks.
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, 1, 0, 0, 1, 0);
      got = V_C;
    end
    check("reach_access_ls", 32'(got), 32'(1));
    step(1, 0, 0, 0, 1, 0);
    check("ls_phase0", 32'(phase), 32'(0));
    check("ls_vckn_held", 32'(VCKn), 32'(1));
    check("ls_still_access", 32'(V_C), 32'(1));
    step(0, 1, 0, 0, 1, 0);
    check("ls_final_vwe", 32'(VWE), 32'(0));
    check("ls_final_vckn", 32'(VCKn), 32'(1));
    step(0, 1, 0, 0, 1, 0);
    check("ls_done_wait_n", 32'(cpu_wait_n), 32'(1));
    step(0, 0, 0, 1, 1, 1);

    // Reset asserted during an access drops every strobe at once.
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, 1, 0, 0, 1, 0);
      got = V_C;
    end
    check("reach_access_rst", 32'(got), 32'(1));
    do_reset("reset_in_access");

    // Random traffic.
    r_vb = 0; r_cs = 1; r_rd = 1; r_wr = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) r_vb = !r_vb;
      if ($urandom_range(0, 5) == 0)   r_cs = !r_cs;
      if ($urandom_range(0, 3) == 0) begin
        r_rd = $urandom_range(0, 1) != 0;
        r_wr = $urandom_range(0, 1) != 0;
      end
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, r_vb, r_cs, r_rd, r_wr);
    end
    step(0, 0, 0, 1, 1, 1);

`ifdef FRONT2_ARB_STATS_EN
    // Counter saturation on a stall held far beyond 16 bits.
    do_reset("reset_stats");
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65600; i++) step(0, 0, 0, 0, 0, 1);
    check("wait_cycles_sat", 32'(wait_cycles), 32'h0000_FFFF);
    step(0, 0, 0, 1, 1, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
